// File: rtl/uc_ctrl.sv
// Sequencing control unit for the 8-bit single-cycle microcontroller datapath.
// Decodes opcode and zero flag into datapath controls and adds run/halt/step sequencing.
module uc_ctrl #(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP
  } state_t;

  localparam logic [5:0] OPC_J    = 6'b110000;
  localparam logic [5:0] OPC_JZ   = 6'b110001;
  localparam logic [5:0] OPC_JNZ  = 6'b110010;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  state_t state, state_n;
  logic   run_q, step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_HALT;
      halted  <= 1'b1;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_n;
      halted  <= (state_n == S_HALT);
      run_q   <= run;
      step_q  <= step;
      if (pc_en)
        retired <= retired + RET_W'(1);
    end
  end

  // Decode is only live in S_RUN/S_STEP; in S_HALT every control sits at its inactive value.
  always_comb begin
    state_n = state;
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    Op      = 3'b000;
    pc_en   = 1'b0;

    if (state != S_HALT) begin
      pc_en = 1'b1;
      if (!Opcode[5]) begin
        Op  = Opcode[4:2];
        we3 = 1'b1;
        wez = 1'b1;
      end else if (Opcode[5:2] == 4'b1000) begin
        s_inm = 1'b1;
        we3   = 1'b1;
      end else begin
        case (Opcode)
          OPC_J:    s_inc = 1'b0;
          OPC_JZ:   s_inc = !z;
          OPC_JNZ:  s_inc = z;
          OPC_HALT: pc_en = 1'b0;
          default:  s_inc = 1'b1;
        endcase
      end
    end

    // Only the rising edge of run/step leaves halt, so a held level cannot restart after HALT.
    case (state)
      S_HALT: begin
        if (run && !run_q)
          state_n = S_RUN;
        else if (step && !step_q)
          state_n = S_STEP;
      end
      S_STEP:  state_n = S_HALT;
      S_RUN: begin
        if (!run || Opcode == OPC_HALT)
          state_n = S_HALT;
      end
      default: state_n = S_HALT;
    endcase
  end

endmodule

// File: doc/uc_ctrl.md
# uc_ctrl

Sequencing control unit for the 8-bit, 10-bit-PC, single-cycle microcontroller datapath. It decodes the 6-bit opcode and the registered zero flag into the datapath control lines (`s_inc`, `s_inm`, `we3`, `wez`, `Op`). It adds run/halt/single-step sequencing through a PC-enable line and keeps a retired-instruction counter. It sits beside the datapath in the top level and is the only source of its control signals.

## Interface
- `RET_W`, default 16, width of the retired-instruction counter.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `Opcode` in 6: instruction bits [15:10] from the datapath.
- `z` in 1: registered zero flag from the datapath.
- `run` in 1: level request to execute continuously; entry is on the rising edge only.
- `step` in 1: single-step request, rising-edge detected.
- `s_inc` out 1: PC mux select; 1 = PC+1, 0 = jump address [9:0].
- `s_inm` out 1: register write-data select; 1 = immediate [11:4], 0 = ALU result.
- `we3` out 1: register-file write enable.
- `wez` out 1: zero-flag write enable.
- `Op` out 3: ALU operation.
- `pc_en` out 1: PC register load enable; 1 = the instruction at PC executes this cycle.
- `halted` out 1: registered; 1 while in S_HALT.
- `retired` out RET_W: count of executed instructions.

## Operation
- States: S_HALT (reset state), S_RUN, S_STEP.
- Internal registers `run_q` and `step_q` hold the previous-cycle `run` and `step`; both reset to 0.
- **S_HALT**
  - `pc_en`=`we3`=`wez`=0.
  - `run`&!`run_q` → S_RUN.
  - Else `step`&!`step_q` → S_STEP.
  - Run has priority over step.
- **S_STEP**
  - Executes exactly one instruction (active decode), then → S_HALT.
  - Holding `step` high produces only one step.
- **S_RUN**
  - Active decode every cycle.
  - `run`=0 → S_HALT; the current-cycle instruction still executes.
  - HALT opcode → S_HALT.
- **Active decode** (S_RUN/S_STEP only):
  - Opcode[5]=0, ALU: `Op`=Opcode[4:2], `we3`=1, `wez`=1, `s_inm`=0, `s_inc`=1.
  - Opcode[5:2]=4'b1000, LI: `s_inm`=1, `we3`=1, `wez`=0, `s_inc`=1.
  - 6'b110000, J: `s_inc`=0.
  - 6'b110001, JZ: `s_inc`=!`z`.
  - 6'b110010, JNZ: `s_inc`=`z`.
  - 6'b111111, HALT: `pc_en`=0, no writes, next state S_HALT. HALT is terminal: a resume re-executes it and returns to S_HALT after 1 cycle.
  - All other opcodes are NOP: `pc_en`=1, no writes, `s_inc`=1.
  - `pc_en`=1 for every active-decode opcode except HALT.
- **Inactive outputs** (S_HALT): `s_inc`=1, `s_inm`=0, `Op`=3'b000, `we3`=`wez`=`pc_en`=0.
- **Counter:** `retired` increments by 1 in each cycle with `pc_en`=1; it wraps from all-ones to 0.

## Timing
- Decode outputs (`s_inc`, `s_inm`, `we3`, `wez`, `Op`, `pc_en`) are combinational from state, `Opcode` and `z`. They are valid in the same cycle, with zero latency.
- State, `halted`, `retired`, `run_q` and `step_q` are registered.
- Reset values: state S_HALT, `halted`=1, `retired`=0, decode outputs at their inactive values.
- `reset` asserted in any state, mid-run or mid-step, wins at the next edge; the current-cycle decode is still driven.
- Run rising edge at cycle n gives first execution at n+1 and `halted`=0 from n+1.
- Step edge at cycle n gives execution at n+1 and S_HALT at n+2.
- `run` falling at cycle n (in S_RUN) executes cycle n; S_HALT from n+1.
- `z` is sampled in the same cycle as the JZ/JNZ decode. The flag written by the previous ALU instruction is the one used.

## Test plan
- **Reset:** hold `reset` 2 cycles → `halted`=1, `retired`=0, `pc_en`=`we3`=`wez`=0, `s_inc`=1.
- **Decode sweep in S_RUN:**
  - Opcode 6'b010100 → `Op`=3'b101, `we3`=`wez`=1.
  - 6'b100011 → `s_inm`=1, `wez`=0.
  - JZ with `z`=1 → `s_inc`=0; with `z`=0 → `s_inc`=1.
  - JNZ is the inverse.
- **Single step:** step held high 5 cycles from halt → exactly one cycle with `pc_en`=1, `retired` 0→1, `halted` back to 1.
- **Run then HALT:** run rises, 3 NOPs, then 6'b111111 → `retired`=3, HALT cycle has `pc_en`=0, `halted`=1 next cycle; `run` still high causes no restart.
- **Counter wrap and priority:**
  - Set `RET_W`=4 and run 17 instructions → `retired`=1.
  - Simultaneous `run`/`step` edges from halt → S_RUN.
- **Reset mid-run:** `reset` during S_RUN → next cycle `halted`=1, `retired`=0, `pc_en`=0.
